// File: rtl/mux_arb_pkg.sv
// Shared widths, arbiter state encoding and a one-hot helper for the 4-channel mux arbiter.
// Pure declarations: no logic, no latency, no flow control.
package mux_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner pick: first set req bit scanning ptr, ptr+1, ... modulo NUM_CH.
// Purely combinational (zero latency); no flow control, any=0 when nothing requests.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  // Scan from the far end back toward ptr so the closest candidate is written last.
  always_comb begin
    idx = ptr;
    any = |req;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for a 4:1 mux: one-hot grant plus registered select, 1-cycle grant latency.
// Owner holds until done, request drop or TIMEOUT cycles; at least one idle cycle between grants.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       tmo
);

  localparam bit                TMO_EN   = (TIMEOUT > 0);
  localparam int                TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0]  CNT_LAST = TO_LAST[CNT_W-1:0];

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic [SEL_W-1:0]  owner;
  logic              owner_rel;
  logic              tmo_hit;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The registered select doubles as the owner index while busy.
  assign owner     = {s1, s0};
  assign owner_rel = done || !req[owner];
  assign tmo_hit   = TMO_EN && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      s1    <= 1'b0;
      s0    <= 1'b0;
      busy  <= 1'b0;
      tmo   <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            gnt      <= onehot(pick_idx);
            {s1, s0} <= pick_idx;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        GRANT: begin
          // A voluntary release on the expiry edge wins, so tmo only marks forced exits.
          if (owner_rel || tmo_hit) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= owner + SEL_W'(1);
            tmo   <= !owner_rel;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench: stimulus queues one expected record per grant; the monitor closes it when busy falls.
module tb_mux_sel_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic       done  = 1'b0;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       tmo;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .busy  (busy),
    .tmo   (tmo)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    int         len;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Data inputs of the 4:1 mux that s1/s0 steer.
  logic [7:0] din [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic       prev_busy = 1'b0;
  logic [3:0] cur_gnt   = 4'b0000;
  logic [1:0] cur_sel   = 2'b00;
  logic [1:0] last_sel  = 2'b00;
  int         cur_len   = 0;

  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      if (!prev_busy) begin
        cur_gnt = gnt;
        cur_sel = {s1, s0};
        cur_len = 0;
      end
      cur_len++;
      chk("gnt_onehot", $countones(gnt), 1);
      chk("gnt_stable", gnt, cur_gnt);
      chk("sel_stable", {s1, s0}, cur_sel);
      chk("mux_pass", din[{s1, s0}], din[enc(gnt)]);
      last_sel = {s1, s0};
    end else begin
      if (prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got gnt %0h expected none at %0t", cur_gnt, $time);
        end else begin
          e = exp_q.pop_front();
          chk("grant_gnt", cur_gnt, e.gnt);
          chk("grant_sel", cur_sel, e.sel);
          chk("grant_len", cur_len, e.len);
          chk("grant_tmo", tmo, e.tmo);
        end
      end
      if (!rst_n) last_sel = 2'b00;
      chk("idle_gnt", gnt, 0);
      chk("idle_sel_hold", {s1, s0}, last_sel);
    end
    if (tmo === 1'b1) chk("tmo_at_fall", prev_busy && (busy !== 1'b1), 1);
    prev_busy = (busy === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] s, input int l, input logic t);
    exp_t e;
    e.gnt = g;
    e.sel = s;
    e.len = l;
    e.tmo = t;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", {s1, s0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // single request, released by done
    push(4'b0001, 2'd0, 1, 1'b0);
    req = 4'b0001;
    cyc(1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    req  = 4'b0000;
    cyc(2);

    // all requesting: rotation 0,1,2,3,0 from a freshly reset pointer
    do_reset();
    push(4'b0001, 2'd0, 1, 1'b0);
    push(4'b0010, 2'd1, 1, 1'b0);
    push(4'b0100, 2'd2, 1, 1'b0);
    push(4'b1000, 2'd3, 1, 1'b0);
    push(4'b0001, 2'd0, 1, 1'b0);
    req = 4'b1111;
    repeat (5) begin
      cyc(1);
      done = 1'b1;
      cyc(1);
      done = 1'b0;
    end
    req = 4'b0000;
    cyc(2);

    // timeout after 8 cycles, regrant after idle cycle, then owner drops req
    push(4'b0100, 2'd2, 8, 1'b1);
    push(4'b0100, 2'd2, 1, 1'b0);
    req = 4'b0100;
    cyc(1);
    cyc(8);
    cyc(1);
    req = 4'b0000;
    cyc(1);
    cyc(2);

    // done on the expiry edge: full length, no tmo
    push(4'b0010, 2'd1, 8, 1'b0);
    req = 4'b0010;
    cyc(1);
    cyc(7);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    req  = 4'b0000;
    cyc(2);

    // reset mid-grant between edges, then regrant after release
    push(4'b1000, 2'd3, 2, 1'b0);
    push(4'b1000, 2'd3, 1, 1'b0);
    req = 4'b1000;
    cyc(1);
    cyc(2);
    #2;
    do_reset();
    cyc(1);
    req = 4'b0000;
    cyc(1);
    cyc(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, max grant length in cycles (range 1..15); 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  4  per-channel request; bit i requests mux input i.
REQ-005 SHALL have port done  input  1  current owner releases the mux; sampled only while busy=1.
REQ-006 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-007 SHALL have port s1  output  1  mux select MSB, registered; drives the 4:1 mux s1.
REQ-008 SHALL have port s0  output  1  mux select LSB, registered; drives the 4:1 mux s0.
REQ-009 SHALL have port busy  output  1  a grant is active, registered.
REQ-010 SHALL have port tmo  output  1  one-cycle pulse when a grant ends by timeout.

Function
REQ-011 SHALL implement two states, IDLE and GRANT; reset state IDLE.
REQ-012 SHALL, in IDLE with req!=0 at an edge, enter GRANT with the winner's gnt bit, {s1,s0}=winner index and busy=1, all visible after that same edge (1-cycle latency).
REQ-013 SHALL pick the winner as the first set req bit scanning ptr, ptr+1, ... modulo 4.
REQ-014 SHALL, in IDLE with req==0, stay in IDLE with gnt=0, busy=0 and {s1,s0} holding the last granted index.
REQ-015 SHALL keep gnt, {s1,s0} and busy constant throughout GRANT; no preemption.
REQ-016 SHALL leave GRANT on the first edge where done=1, req[owner]=0, or the timeout expires, clearing gnt and busy and returning to IDLE.
REQ-017 SHALL update ptr to (owner+1) mod 4, wrapping 3->0, on every GRANT exit.
REQ-018 SHALL force at least one IDLE cycle between consecutive grants, so busy=0 for at least one cycle.
REQ-019 SHALL clear the hold counter (4 bits) on GRANT entry and increment it each GRANT cycle.
REQ-020 SHALL expire the timeout when the counter equals TIMEOUT-1 (owner holds exactly TIMEOUT cycles); done or req drop on the same edge takes precedence, and tmo stays 0.
REQ-021 SHALL assert tmo for exactly one cycle, coincident with busy falling, only on a timeout exit.
REQ-022 SHALL never assert more than one gnt bit, and SHALL keep {s1,s0} equal to the gnt index whenever busy=1.
REQ-023 SHALL ignore done while in IDLE.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state=IDLE, gnt=0, s1=0, s0=0, busy=0, tmo=0, ptr=0 and counter=0, regardless of clk.
REQ-025 SHALL abort a grant in progress on reset with no tmo pulse; after release, arbitration restarts from ptr=0.
REQ-026 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take NUM_CH=4, SEL_W=2, CNT_W=4 and the state enum {IDLE, GRANT} from shared package mux_arb_pkg.
REQ-028 SHALL place the winner selection in one combinational sub-module, rr_pick (inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and any).
REQ-029 SHALL register every output; there is no combinational path from inputs to outputs.

Verification
REQ-030 SHALL cover: reset, then req=0001 -> after 1 edge gnt=0001, {s1,s0}=00, busy=1; assert done -> gnt=0000, busy=0 next edge, ptr=1.
REQ-031 SHALL cover: req=1111 held, done pulsed each grant -> grant order 0,1,2,3,0 with {s1,s0}=00,01,10,11,00 and one IDLE cycle between grants.
REQ-032 SHALL cover: TIMEOUT=8, req=0100 held, done=0 -> gnt=0100 for exactly 8 cycles, tmo=1 for 1 cycle as busy falls, next grant to channel 2 after the IDLE cycle.
REQ-033 SHALL cover: done=1 on the same edge the counter reaches 7 -> exit with tmo=0.
REQ-034 SHALL cover: rst_n pulled low mid-grant, between clock edges -> outputs 0 immediately; after release with req=1000 -> gnt=1000 (ptr restarted at 0).
REQ-035 SHALL cover: owner drops req with done=0 -> busy=0 next edge, tmo=0, and a 4:1 mux driven by s1/s0 passes the granted input during every busy cycle.
